ga2x_vram_sched: RTL and testbench

- Parametrised VRAM time-slot scheduler for GA2x-family tilemap video chips; successor to the fixed 3-layer slot sequencer inside the GA23 top level.
- Shares one single-port VRAM between NUM_LAYERS tile-fetch engines, one CPU access port and a per-scanline rowscroll fetcher.
- Sits between the video timing/CPU bus logic and the per-layer tile engines.
- Supports any layer count, address width and rowscroll table base, and has a CPU-priority boost mode that the fixed sequencer lacks.

---
 rtl/ga2x_vram_sched.sv | 202 ++++++++++++++++++++
 tb/tb_ga2x_vram_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ga2x_vram_sched.sv
// ga2x_vram_sched: VRAM time-slot scheduler for GA2x tilemap chips.
// One single-port VRAM is shared by NUM_LAYERS tile fetchers, a CPU port
// and an optional per-line rowscroll fetcher.
// Round of L = 2*NUM_LAYERS+2 slots: an even/odd slot pair per layer, then
// one CPU slot pair.
// With cpu_boost set, the even slot of each odd-numbered layer also serves
// a pending CPU access.
// Optional feature macro: ROWSCROLL_FETCH_EN builds the per-line rowscroll
// fetch state (RS). Without it, rowscroll is tied to zero, and hpulse only
// realigns the slot counter.
module ga2x_vram_sched #(
   parameter int NUM_LAYERS  = 3,
   parameter int AW          = 15,
   parameter int RS_BASE     = 'h7a00,
   parameter int RS_PREFETCH = 'h7800
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       ce,
   input  logic                       hpulse,
   input  logic [9:0]                 vcnt,
   input  logic [NUM_LAYERS*10-1:0]   y_ofs,
   input  logic                       cpu_boost,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [AW-1:0]              cpu_addr,
   input  logic [15:0]                cpu_din,
   output logic [15:0]                cpu_dout,
   output logic                       cpu_busy,
   input  logic [NUM_LAYERS*AW-1:0]   layer_addr,
   output logic [NUM_LAYERS-1:0]      layer_load,
   output logic [15:0]                vram_latch,
   output logic [AW-1:0]              vram_addr,
   output logic [15:0]                vram_dout,
   output logic                       vram_we,
   input  logic [15:0]                vram_din,
   output logic [NUM_LAYERS*10-1:0]   rowscroll
);

   localparam int              L         = 2 * NUM_LAYERS + 2;
   localparam int              SW        = $clog2(L);
   localparam logic [SW-1:0]   SLOT_LAST = SW'(L - 1);
   localparam logic [SW-1:0]   SLOT_CPU  = SW'(2 * NUM_LAYERS);

   logic [SW-1:0]          slot;
   logic                   cpu_pend;
   logic                   cpu_inflight;
   logic                   cpu_we_q;
   logic [AW-1:0]          cpu_addr_q;
   logic [15:0]            cpu_din_q;

   logic                   in_rs;
   logic                   is_layer;
   logic                   serve_now;
   logic                   done_now;
   logic [SW-2:0]          lidx;
   logic [AW-1:0]          lay_word;
   logic [NUM_LAYERS-1:0]  lay_onehot;

`ifdef ROWSCROLL_FETCH_EN
   localparam int            RCW     = $clog2(2 * NUM_LAYERS + 1);
   localparam logic [RCW-1:0] RC_LAST = RCW'(2 * NUM_LAYERS);

   typedef enum logic {ST_SLOTS, ST_RS} state_t;

   state_t                 state;
   logic [RCW-1:0]         rc;
   logic                   rs_pending;
   logic [AW-1:0]          rs_addr;
   logic [9:0]             rs_sum;

   // Rowscroll table address for the layer addressed by the current odd rc.
   always_comb begin
      rs_sum  = '0;
      rs_addr = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (rc == RCW'(2 * i + 1)) begin
            rs_sum  = y_ofs[i*10 +: 10] + vcnt;
            rs_addr = AW'(RS_BASE + i * 'h200 + int'(rs_sum[8:0]));
         end
      end
   end

   assign in_rs = (state == ST_RS);
`else
   assign in_rs     = 1'b0;
   assign rowscroll = '0;
`endif

   // Slot decode and CPU service/completion decisions for this ce.
   always_comb begin
      lidx       = slot[SW-1:1];
      is_layer   = (slot < SLOT_CPU);
      lay_word   = layer_addr[int'(lidx)*AW +: AW];
      lay_onehot = NUM_LAYERS'(1) << lidx;
      serve_now  = ce && !in_rs && cpu_pend && !slot[0] &&
                   (!is_layer || (cpu_boost && slot[1]));
      done_now   = ce && !in_rs && cpu_inflight && slot[0];
   end

   // Scheduler state machine: slot round, CPU port and rowscroll fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot         <= '0;
         cpu_pend     <= 1'b0;
         cpu_inflight <= 1'b0;
         cpu_busy     <= 1'b0;
         cpu_we_q     <= 1'b0;
         cpu_addr_q   <= '0;
         cpu_din_q    <= '0;
         cpu_dout     <= '0;
         layer_load   <= '0;
         vram_latch   <= '0;
         vram_addr    <= '0;
         vram_dout    <= '0;
         vram_we      <= 1'b0;
`ifdef ROWSCROLL_FETCH_EN
         state        <= ST_SLOTS;
         rc           <= '0;
         rs_pending   <= 1'b0;
         rowscroll    <= '0;
`endif
      end else begin
         // NOTE: vram_we defaults low on every clk, not every ce, so a
         // write strobe is exactly one clk wide even when ce is sparse.
         vram_we <= 1'b0;

         // CPU request capture runs on clk; requests while busy are dropped.
         if (cpu_req && !cpu_busy) begin
            cpu_busy   <= 1'b1;
            cpu_pend   <= 1'b1;
            cpu_we_q   <= cpu_we;
            cpu_addr_q <= cpu_addr;
            cpu_din_q  <= cpu_din;
         end

         if (serve_now) begin
            vram_addr    <= cpu_addr_q;
            vram_dout    <= cpu_din_q;
            vram_we      <= cpu_we_q;
            cpu_pend     <= 1'b0;
            cpu_inflight <= 1'b1;
         end

         if (done_now) begin
            cpu_dout     <= vram_din;
            cpu_busy     <= 1'b0;
            cpu_inflight <= 1'b0;
         end

         if (ce) begin
            layer_load <= '0;
            if (in_rs) begin
`ifdef ROWSCROLL_FETCH_EN
               if (rc == '0)
                  vram_addr <= AW'(RS_PREFETCH);
               else if (rc[0])
                  vram_addr <= rs_addr;
               for (int i = 0; i < NUM_LAYERS; i++) begin
                  if (rc == RCW'(2 * i + 2))
                     rowscroll[i*10 +: 10] <= vram_din[9:0];
               end
               if (rc == RC_LAST) begin
                  state      <= ST_SLOTS;
                  slot       <= '0;
                  rs_pending <= 1'b0;
               end else begin
                  rc <= rc + 1'b1;
               end
`endif
            end else begin
               if (is_layer && !slot[0] && !serve_now)
                  vram_addr <= {lay_word[AW-1:1], 1'b0};
               if (is_layer && slot[0]) begin
                  vram_addr[0] <= 1'b1;
                  layer_load   <= lay_onehot;
                  // A boosted CPU access used this pair: latch stays stale.
                  if (!cpu_inflight)
                     vram_latch <= vram_din;
               end

               if (hpulse)
                  slot <= SLOT_LAST;
               else if (slot == SLOT_LAST)
                  slot <= '0;
               else
                  slot <= slot + 1'b1;

`ifdef ROWSCROLL_FETCH_EN
               if (hpulse)
                  rs_pending <= 1'b1;
               if (slot == SLOT_LAST && rs_pending) begin
                  state <= ST_RS;
                  rc    <= '0;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_ga2x_vram_sched.sv
// Directed testbench for ga2x_vram_sched (default 3-layer build plus a
// 4-layer, 16-bit-address instance). Rowscroll checks follow the
// ROWSCROLL_FETCH_EN macro.
module tb_ga2x_vram_sched;

   logic        clk = 1'b0;
   logic        reset_n, ce, hpulse, cpu_boost, cpu_req, cpu_we;
   logic [9:0]  vcnt;
   logic [29:0] y_ofs;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_din, cpu_dout, vram_latch, vram_dout, vram_din;
   logic        cpu_busy, vram_we;
   logic [44:0] layer_addr;
   logic [2:0]  layer_load;
   logic [14:0] vram_addr;
   logic [29:0] rowscroll;

   logic        rst4_n, hpulse4, cpu_req4, cpu_busy4, vram_we4;
   logic [9:0]  vcnt4;
   logic [39:0] y_ofs4, rowscroll4;
   logic [15:0] cpu_addr4, cpu_dout4, vram_latch4, vram_dout4, vram_addr4;
   logic [63:0] layer_addr4;
   logic [3:0]  layer_load4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ga2x_vram_sched u_dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .hpulse(hpulse), .vcnt(vcnt),
      .y_ofs(y_ofs), .cpu_boost(cpu_boost), .cpu_req(cpu_req),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_busy(cpu_busy), .layer_addr(layer_addr),
      .layer_load(layer_load), .vram_latch(vram_latch),
      .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_we(vram_we),
      .vram_din(vram_din), .rowscroll(rowscroll)
   );

   ga2x_vram_sched #(.NUM_LAYERS(4), .AW(16)) u_dut4 (
      .clk(clk), .reset_n(rst4_n), .ce(ce), .hpulse(hpulse4), .vcnt(vcnt4),
      .y_ofs(y_ofs4), .cpu_boost(1'b0), .cpu_req(cpu_req4),
      .cpu_we(1'b1), .cpu_addr(cpu_addr4), .cpu_din(16'h0001),
      .cpu_dout(cpu_dout4), .cpu_busy(cpu_busy4), .layer_addr(layer_addr4),
      .layer_load(layer_load4), .vram_latch(vram_latch4),
      .vram_addr(vram_addr4), .vram_dout(vram_dout4), .vram_we(vram_we4),
      .vram_din(16'h0000), .rowscroll(rowscroll4)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clk; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 0; ce = 0; hpulse = 0; cpu_boost = 0; cpu_req = 0; cpu_we = 0;
      cpu_addr = '0; cpu_din = '0; vram_din = '0; vcnt = 10'd10;
      y_ofs = {10'd1000, 10'd20, 10'd505};
      layer_addr = {15'h0A40, 15'h0124, 15'h0010};
      rst4_n = 0; hpulse4 = 0; cpu_req4 = 0; vcnt4 = '0; y_ofs4 = '0;
      cpu_addr4 = '0;
      layer_addr4 = {16'h4000, 16'h3000, 16'h2000, 16'h1000};

      step(); step();
      check("rst_addr", vram_addr, 0);
      check("rst_load", layer_load, 0);
      check("rst_busy", cpu_busy, 0);
      check("rst_we", vram_we, 0);
      check("rst_rowscroll", rowscroll, 0);

      // Layer slots
      reset_n = 1; ce = 1; vram_din = 16'h1111;
      step();                                   // slot 0
      check("s0_addr", vram_addr, 15'h0010);
      step();                                   // slot 1
      check("s1_addr", vram_addr, 15'h0011);
      check("s1_latch", vram_latch, 16'h1111);
      check("s1_load", layer_load, 3'b001);
      vram_din = 16'hABCD;
      step();                                   // slot 2
      check("s2_addr", vram_addr, 15'h0124);
      check("s2_load", layer_load, 3'b000);
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0777;
      step();                                   // slot 3
      cpu_req = 0;
      check("s3_latch", vram_latch, 16'hABCD);
      check("s3_load", layer_load, 3'b010);
      check("s3_addr", vram_addr, 15'h0125);
      check("s3_busy", cpu_busy, 1);

      // Asynchronous reset mid-round
      #2 reset_n = 0;
      #1;
      check("arst_addr", vram_addr, 0);
      check("arst_load", layer_load, 0);
      check("arst_busy", cpu_busy, 0);
      check("arst_latch", vram_latch, 0);
      step();
      reset_n = 1;

      // CPU write served in the CPU slot, ce gap after the write
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h1000; cpu_din = 16'h5A5A;
      step();                                   // slot 0
      cpu_req = 0;
      check("w_first_addr", vram_addr, 15'h0010);
      check("w_busy", cpu_busy, 1);
      check("w_we_early", vram_we, 0);
      repeat (5) step();                        // slots 1..5
      check("w_busy_wait", cpu_busy, 1);
      check("w_we_wait", vram_we, 0);
      step();                                   // slot 6
      check("w_we", vram_we, 1);
      check("w_addr", vram_addr, 15'h1000);
      check("w_dout", vram_dout, 16'h5A5A);
      ce = 0;
      step();                                   // no ce
      check("w_we_clear", vram_we, 0);
      check("w_busy_hold", cpu_busy, 1);
      check("w_addr_hold", vram_addr, 15'h1000);
      ce = 1;
      step();                                   // slot 7
      check("w_busy_done", cpu_busy, 0);

      // CPU read, second request while busy is ignored
      cpu_req = 1; cpu_we = 0; cpu_addr = 15'h2222;
      step();                                   // slot 0
      cpu_req = 0;
      step();                                   // slot 1
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h3333;
      step();                                   // slot 2
      cpu_req = 0;
      repeat (3) step();                        // slots 3..5
      vram_din = 16'hBEEF;
      step();                                   // slot 6
      check("r_addr", vram_addr, 15'h2222);
      check("r_we", vram_we, 0);
      step();                                   // slot 7
      check("r_dout", cpu_dout, 16'hBEEF);
      check("r_busy", cpu_busy, 0);

      // Boost: served in layer 1's even slot, latch left stale
      cpu_boost = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 15'h4444;
      cpu_din = 16'h1234; vram_din = 16'h0F0F;
      step();                                   // slot 0
      cpu_req = 0;
      step();                                   // slot 1
      check("b_latch0", vram_latch, 16'h0F0F);
      vram_din = 16'h7777;
      step();                                   // slot 2
      check("b_we", vram_we, 1);
      check("b_addr", vram_addr, 15'h4444);
      check("b_dout", vram_dout, 16'h1234);
      step();                                   // slot 3
      check("b_busy", cpu_busy, 0);
      check("b_load", layer_load, 3'b010);
      check("b_latch_stale", vram_latch, 16'h0F0F);
      check("b_cpu_dout", cpu_dout, 16'h7777);
      cpu_boost = 0;
      repeat (4) step();                        // slots 4..7

      // hpulse forces the counter to the last slot
      step(); step();                           // slots 0, 1
      hpulse = 1;
      step();                                   // slot 2, counter -> 7
      hpulse = 0;
      check("h_addr", vram_addr, 15'h0124);
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h5555; cpu_din = 16'h6666;
`ifdef ROWSCROLL_FETCH_EN
      step();                                   // slot 7 -> RS
      cpu_req = 0;
      step();                                   // rc0
      check("rs_prefetch", vram_addr, 15'h7800);
      check("rs_busy", cpu_busy, 1);
      step();                                   // rc1
      check("rs_addr0", vram_addr, 15'h7a03);
      vram_din = 16'h0123; hpulse = 1;
      step();                                   // rc2 (hpulse ignored)
      hpulse = 0;
      check("rs_val0", rowscroll[9:0], 10'h123);
      check("rs_load", layer_load, 0);
      step();                                   // rc3
      check("rs_addr1", vram_addr, 15'h7c1e);
      vram_din = 16'hFFFF;
      step();                                   // rc4
      check("rs_val1", rowscroll[19:10], 10'h3FF);
      step();                                   // rc5
      check("rs_addr2", vram_addr, 15'h7ff2);
      vram_din = 16'h0200;
      step();                                   // rc6
      check("rs_val2", rowscroll[29:20], 10'h200);
      check("rs_we", vram_we, 0);
      step();                                   // slot 0
      check("rs_exit_addr", vram_addr, 15'h0010);
`else
      step();                                   // slot 7
      cpu_req = 0;
      check("h_addr_hold", vram_addr, 15'h0124);
      check("h_rowscroll", rowscroll, 0);
      step();                                   // slot 0
      check("h_wrap_addr", vram_addr, 15'h0010);
`endif
      repeat (5) step();                        // slots 1..5
      step();                                   // slot 6
      check("h_cpu_we", vram_we, 1);
      check("h_cpu_addr", vram_addr, 15'h5555);
      step();                                   // slot 7
      check("h_cpu_busy", cpu_busy, 0);

      // Four-layer, 16-bit-address instance: round length 10
      rst4_n = 1; cpu_req4 = 1; cpu_addr4 = 16'hF00E;
      step();                                   // slot 0
      cpu_req4 = 0;
      check("n4_s0_addr", vram_addr4, 16'h1000);
      repeat (6) step();                        // slots 1..6
      check("n4_s6_addr", vram_addr4, 16'h4000);
      step();                                   // slot 7
      check("n4_s7_load", layer_load4, 4'b1000);
      check("n4_s7_we", vram_we4, 0);
      step();                                   // slot 8
      check("n4_cpu_we", vram_we4, 1);
      check("n4_cpu_addr", vram_addr4, 16'hF00E);
      step();                                   // slot 9
      check("n4_cpu_busy", cpu_busy4, 0);
`ifdef ROWSCROLL_FETCH_EN
      hpulse4 = 1;
      step();                                   // slot 0, counter -> 9
      hpulse4 = 0;
      step();                                   // slot 9 -> RS
      repeat (8) step();                        // rc0..rc7
      check("n4_rs_addr3", vram_addr4, 16'h8000);
      step();                                   // rc8
      step();                                   // slot 0
      check("n4_rs_exit", vram_addr4, 16'h1000);
`else
      step();                                   // slot 0 after wrap
      check("n4_wrap_addr", vram_addr4, 16'h1000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
